// File: rtl/adder_pkg.sv
// Constants shared by the adder result collector: data width default,
// control-tag width, flag bit positions and the stored entry width.
package adder_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CTRL_W    = 5;
    localparam int FLAG_W    = 4;

    // Flag bit positions inside the 4-bit {C,V,N,Z} flag word
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    localparam int ENTRY_W_DEF = WIDTH_DEF + FLAG_W + CTRL_W;

    // Width of one stored result {sum, flags, ctrl} for a given sum width
    function automatic int entry_w(input int width);
        return width + FLAG_W + CTRL_W;
    endfunction

endpackage

// File: rtl/adder_result_collector_if.sv
// Result stream interface between the collector and its consumer.
// Handshake: a transfer happens on a rising clk edge where res_valid and
// res_ready are both 1. While res_valid=1 and res_ready=0 the producer holds
// res_data/res_flags/res_tag stable. res_ready while res_valid=0 is ignored.
interface adder_result_collector_if
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic              res_valid;
    logic              res_ready;
    logic [WIDTH-1:0]  res_data;
    logic [FLAG_W-1:0] res_flags;
    logic [CTRL_W-1:0] res_tag;

    modport master (
        output res_valid,
        output res_data,
        output res_flags,
        output res_tag,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_flags,
        input  res_tag,
        output res_ready
    );
endinterface

// File: rtl/adder_result_collector_sync_fifo.sv
// Show-ahead synchronous FIFO. Head data appears combinationally from
// storage and reads as zero when empty. A push is taken when not full,
// or when full with a pop in the same cycle (the freed slot is reused).
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_wdata,
    output logic [W-1:0]               o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH (power of two)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset since the output is masked when empty
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/adder_result_collector.sv
// Collects adder results: one capture per rising edge of out_en, computes
// {C,V,N,Z} flags, queues {sum, flags, ctrl} in a FIFO and presents the
// head on a valid/ready stream. drop_err latches if a result is lost.
module adder_result_collector
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    out_en,
    input  logic [WIDTH-1:0]        sum,
    input  logic                    cout,
    input  logic                    a_msb,
    input  logic                    b_msb,
    input  logic [CTRL_W-1:0]       ctrl,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    drop_err,
    adder_result_collector_if.master res
);
    localparam int EW = entry_w(WIDTH);

    logic              r_out_en_q;
    logic              r_drop_err;
    logic              w_capture;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    logic [FLAG_W-1:0] w_flags;
    logic [EW-1:0]     w_wdata;
    logic [EW-1:0]     w_rdata;

    assign w_capture = out_en & ~r_out_en_q;

    // Flag generation from the sum and operand sign bits
    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_C] = cout;
        w_flags[FLAG_V] = (a_msb == b_msb) & (sum[WIDTH-1] != a_msb);
        w_flags[FLAG_N] = sum[WIDTH-1];
        w_flags[FLAG_Z] = (sum == '0);
    end

    assign w_wdata = {sum, w_flags, ctrl};
    assign w_pop   = res.res_valid & res.res_ready;
    assign w_drop  = w_capture & w_full & ~w_pop;

    // Registered out_en for rising-edge detection; cleared so a level already
    // high when reset releases is seen as a new pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_out_en_q <= 1'b0;
        else     r_out_en_q <= out_en;
    end

    // Sticky loss indicator, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_drop_err <= 1'b0;
        else if (w_drop) r_drop_err <= 1'b1;
    end

    sync_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_capture),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    assign res.res_valid = ~w_empty;
    assign res.res_data  = w_rdata[EW-1 -: WIDTH];
    assign res.res_flags = w_rdata[CTRL_W +: FLAG_W];
    assign res.res_tag   = w_rdata[CTRL_W-1:0];
    assign drop_err      = r_drop_err;

endmodule
